ripple_carry_adder_4bit: RTL and testbench
==========================================

Name: ripple_carry_adder_4bit

Overview:
- 4-bit unsigned/two's-complement adder built as an explicit ripple chain of one-bit full-adder cells.
- Operands a, b and carry-in cin are combined combinationally.
- Result is captured in an output register, giving one cycle of latency.
- Leaf arithmetic block for datapaths that need a registered small adder with carry-out and status flags.

Parameters:
- WIDTH, 4, operand and sum width in bits; the chain has WIDTH cells. Only 4 is required to be verified; any WIDTH ≥ 1 must elaborate.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on a/b/cin are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout/flags hold a new result.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of the MSB cell.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered flag, 1 when sum == 0.

Behaviour:
- Combinational datapath is a ripple chain: c[0] = cin; for cell i, s[i] = a[i]^b[i]^c[i] and c[i+1] = (a[i]&b[i]) | (b[i]&c[i]) | (a[i]&c[i]); cout_comb = c[WIDTH].
- Use no behavioural "+" for the sum; use no gate delays in RTL.
- Reset (rst_n low, asynchronous): sum=0, cout=0, ovf=0, zero=0, out_valid=0. Outputs hold these values until the first valid capture after reset release.
- Each rising clk with rst_n high: out_valid <= in_valid.
- If in_valid=1, register sum, cout, ovf and zero from the current a/b/cin.
- If in_valid=0, sum, cout, ovf and zero hold their previous values.
- Latency is exactly 1 cycle. Throughput is one operation per cycle. There is no backpressure.
- Wrap-around: the full result is {cout, sum}. 15+1+0 gives sum=0000, cout=1, zero=1.
- Reset asserted mid-stream clears outputs immediately. The first result after release appears one cycle after the first in_valid=1 edge.
- X on inputs while in_valid=0 must not propagate to the outputs.

Decomposition:
- Shared package rca_pkg holds RCA_DEFAULT_WIDTH = 4 and a typedef for the WIDTH-bit operand/sum vector.
- One sub-module, rca_fa_cell: a purely combinational one-bit full adder with inputs a, b, ci and outputs s, co. Instantiate it WIDTH times via generate.
- The top level holds the carry vector, the flag logic and the output register.

Test Plan:
- Reset: rst_n=0 with random inputs -> sum=0000, cout=0, ovf=0, zero=1?? No: zero=0, out_valid=0 throughout reset. Release reset, then a=0000, b=0000, cin=0, in_valid=1 -> next cycle sum=0000, cout=0, zero=1, out_valid=1.
- a=0101, b=0011, cin=0, in_valid=1 -> next cycle sum=1000, cout=0, ovf=1 (5+3 overflows signed 4-bit), zero=0.
- a=1111, b=0001, cin=0 -> sum=0000, cout=1, ovf=0, zero=1.
- a=1010, b=0101, cin=1 -> sum=0000, cout=1, zero=1. Then a=1111, b=1111, cin=1 -> sum=1111, cout=1, ovf=0.
- Hold/valid: drive in_valid=0 with new operands -> outputs unchanged and out_valid=0. Assert rst_n=0 between clock edges -> outputs clear immediately.
- Exhaustive: all 512 combinations of a, b, cin with in_valid=1 back-to-back. Each cycle check {cout, sum} == a+b+cin from the prior cycle, and check ovf and zero against the reference model.

Source files
------------

// File: rtl/ripple_carry_adder_4bit_pkg.sv
// Shared width constant and operand type for the ripple-carry adder.
// Latency: none (declarations only).
// Backpressure: none.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;

    typedef logic [RCA_DEFAULT_WIDTH-1:0] rca_word_t;

endpackage

// File: rtl/ripple_carry_adder_4bit_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// Latency: n/a (wiring only).
// Backpressure: none; the result side is valid-only.
interface ripple_carry_adder_4bit_if #(
    parameter int WIDTH = rca_pkg::RCA_DEFAULT_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/ripple_carry_adder_4bit_fa_cell.sv
// One-bit full adder cell of the ripple chain.
// Latency: purely combinational.
// Backpressure: none.
module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (b & ci) | (a & ci);
endmodule

// File: rtl/ripple_carry_adder_4bit.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, overflow and zero flags.
// Latency: 1 cycle, one operation per cycle.
// Backpressure: none; results hold while in_valid is low.
module ripple_carry_adder_4bit
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ripple_carry_adder_4bit_if.slave bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        rca_fa_cell u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign cout_d = carry[WIDTH];
    assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    assign zero_d = ~|sum_d;

    // Capture is gated by in_valid so X on idle operands never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Directed and exhaustive self-checking bench for ripple_carry_adder_4bit.
module tb_ripple_carry_adder_4bit;
    import rca_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   chk_cnt;

    ripple_carry_adder_4bit_if #(.WIDTH(4)) bus ();

    ripple_carry_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input rca_word_t a, input rca_word_t b, input logic cin);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
    endtask

    task automatic op_cycle(input rca_word_t a, input rca_word_t b, input logic cin);
        drive(1'b1, a, b, cin);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rca_word_t'($urandom), rca_word_t'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            chk_cnt++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b0)
                $display("FAIL reset_hold: got v=%b s=%b c=%b o=%b z=%b, want all 0",
                         bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        op_cycle(4'b0000, 4'b0000, 1'b0);
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b1_0000_0_0_1)
            $display("FAIL first_zero_result: got v=%b s=%b c=%b o=%b z=%b, want v=1 s=0000 c=0 o=0 z=1",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        op_cycle(4'b0101, 4'b0011, 1'b0);
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b1_1000_0_1_0)
            $display("FAIL add_5_3: got v=%b s=%b c=%b o=%b z=%b, want v=1 s=1000 c=0 o=1 z=0",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;

        op_cycle(4'b1111, 4'b0001, 1'b0);
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b1_0000_1_0_1)
            $display("FAIL wrap_15_1: got v=%b s=%b c=%b o=%b z=%b, want v=1 s=0000 c=1 o=0 z=1",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;

        op_cycle(4'b1010, 4'b0101, 1'b1);
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b1_0000_1_0_1)
            $display("FAIL add_10_5_cin: got v=%b s=%b c=%b o=%b z=%b, want v=1 s=0000 c=1 o=0 z=1",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;

        op_cycle(4'b1111, 4'b1111, 1'b1);
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b1_1111_1_0_0)
            $display("FAIL add_15_15_cin: got v=%b s=%b c=%b o=%b z=%b, want v=1 s=1111 c=1 o=0 z=0",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;
    endtask

    task automatic test_hold;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b0;
            bus.a        = (i == 0) ? 4'bxxxx : 4'b0001;
            bus.b        = (i == 0) ? 4'bxxxx : 4'b0001;
            bus.cin      = (i == 0) ? 1'bx : 1'b0;
            @(posedge clk);
            #1;
            chk_cnt++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b0_1111_1_0_0)
                $display("FAIL hold_idle%0d: got v=%b s=%b c=%b o=%b z=%b, want v=0 s=1111 c=1 o=0 z=0",
                         i, bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset;
        op_cycle(4'b0101, 4'b0011, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b0)
            $display("FAIL async_reset: got v=%b s=%b c=%b o=%b z=%b, want all 0",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'b0110, 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b0)
            $display("FAIL post_reset_idle: got v=%b s=%b c=%b o=%b z=%b, want all 0",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;
        op_cycle(4'b0110, 4'b0001, 1'b0);
        chk_cnt++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero} !== 8'b1_0111_0_0_0)
            $display("FAIL first_after_release: got v=%b s=%b c=%b o=%b z=%b, want v=1 s=0111 c=0 o=0 z=0",
                     bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [4:0] full;
        logic       exp_ovf;
        logic       exp_zero;
        rca_word_t  ea;
        rca_word_t  eb;
        logic       ec;
        for (int n = 0; n < 512; n++) begin
            ea = rca_word_t'(n[8:5]);
            eb = rca_word_t'(n[4:1]);
            ec = n[0];
            op_cycle(ea, eb, ec);
            full     = {1'b0, ea} + {1'b0, eb} + {4'b0, ec};
            exp_ovf  = (ea[3] == eb[3]) && (full[3] != ea[3]);
            exp_zero = (full[3:0] == 4'b0000);
            chk_cnt++;
            if ({bus.cout, bus.sum} !== full)
                $display("FAIL exh_sum a=%0d b=%0d cin=%0d: got %0d want %0d", ea, eb, ec, {bus.cout, bus.sum}, full);
            else pass_cnt++;
            chk_cnt++;
            if (bus.ovf !== exp_ovf)
                $display("FAIL exh_ovf a=%0d b=%0d cin=%0d: got %b want %b", ea, eb, ec, bus.ovf, exp_ovf);
            else pass_cnt++;
            chk_cnt++;
            if (bus.zero !== exp_zero || bus.out_valid !== 1'b1)
                $display("FAIL exh_zero_valid a=%0d b=%0d cin=%0d: got z=%b v=%b want z=%b v=1",
                         ea, eb, ec, bus.zero, bus.out_valid, exp_zero);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst_n    = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        #1;
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
